// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sequences the FF46 OAM DMA copy of 160 bytes into OAM.
// Optional macro OAM_DMA_BUS_BLOCK_EN adds the cpu_bus_block output.
module oam_dma_ctrl #(
    parameter int CLKS_PER_BYTE = 4,
    parameter int NUM_BYTES     = 160
) (
    input  logic        clk4,
    input  logic        n_reset2,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic        ff46,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  dma_din,
    output logic [15:0] dma_a,
    output logic        dma_run,
    output logic        dma_addr_ext,
    output logic        vram_to_oam,
    output logic [7:0]  oam_a,
    output logic [7:0]  oam_dout,
    output logic        oam_dma_wr
`ifdef OAM_DMA_BUS_BLOCK_EN
    ,
    output logic        cpu_bus_block
`endif
);

    localparam int PW = 4;
    localparam logic [PW-1:0] PH_CAP = PW'(CLKS_PER_BYTE - 2);
    localparam logic [PW-1:0] PH_WR  = PW'(CLKS_PER_BYTE - 1);
    localparam logic [PW-1:0] PH_GO  = PW'(CLKS_PER_BYTE);
    localparam logic [7:0]    LAST_IDX = 8'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        XFER  = 2'b10
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   phase_q;
    logic [PW-1:0]   phase_d;
    logic [7:0]      idx_q;
    logic [7:0]      idx_d;
    logic [7:0]      src_hi_q;
    logic [7:0]      data_q;
    logic [15:0]     last_a_q;
    logic [7:0]      eff_hi;
    logic            trigger;
    logic            in_xfer;
    logic            cap_now;

    assign trigger = cpu_wr & ff46;
    assign in_xfer = (state_q == XFER);
    assign cap_now = in_xfer & (phase_q == PH_CAP);

    // Echo RAM (E000-FDFF) mirrors WRAM, so fold high sources down by 0x20.
    assign eff_hi = (src_hi_q >= 8'hE0) ? (src_hi_q - 8'h20) : src_hi_q;

    // FF46 readback is the raw register, never the folded page.
    assign d_oe  = ff46 & cpu_rd;
    assign d_out = d_oe ? src_hi_q : 8'h00;

    // State register; a FF46 write is folded into state_d by the comb block.
    always_ff @(posedge clk4) begin
        if (!n_reset2) begin
            state_q <= IDLE;
            phase_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
        end
    end

    // Datapath: source page, fetched byte and last driven source address.
    always_ff @(posedge clk4) begin
        if (!n_reset2) begin
            src_hi_q <= 8'h00;
            data_q   <= 8'h00;
            last_a_q <= 16'h0000;
        end else begin
            if (trigger) begin
                src_hi_q <= d_in;
            end
            if (cap_now) begin
                data_q <= dma_din;
            end
            if (in_xfer) begin
                last_a_q <= {eff_hi, idx_q};
            end
        end
    end

    // Next-state sequencing and per-byte bus/OAM outputs.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        dma_run    = 1'b0;
        dma_a      = last_a_q;
        oam_dma_wr = 1'b0;
        oam_a      = 8'h00;
        oam_dout   = 8'h00;
        unique case (state_q)
            IDLE: begin
            end
            START: begin
                if (phase_q == PH_GO) begin
                    state_d = XFER;
                    phase_d = '0;
                    idx_d   = '0;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            XFER: begin
                dma_run = 1'b1;
                dma_a   = {eff_hi, idx_q};
                if (phase_q == PH_WR) begin
                    oam_dma_wr = 1'b1;
                    oam_a      = idx_q;
                    oam_dout   = data_q;
                    phase_d    = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A new FF46 write wins over everything, but the strobe above stays.
        if (trigger) begin
            state_d = START;
            phase_d = '0;
            idx_d   = '0;
        end
    end

    assign vram_to_oam  = dma_run & (eff_hi[7:5] == 3'b100);
    assign dma_addr_ext = dma_run & ~vram_to_oam;

`ifdef OAM_DMA_BUS_BLOCK_EN
    logic cpu_in_vram;

    // Block the CPU only from the bus the DMA is currently driving.
    assign cpu_in_vram   = (cpu_a[15:13] == 3'b100);
    assign cpu_bus_block = dma_run
                         & (cpu_a < 16'hFE00)
                         & (cpu_in_vram == vram_to_oam);
`else
    logic unused_cpu_a;

    assign unused_cpu_a = ^cpu_a;
`endif

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: scoreboard bench for oam_dma_ctrl.
// A memory model feeds dma_din; expected OAM writes are queued per trigger.
`timescale 1ns/1ps
module tb_oam_dma_ctrl;

    localparam int CPB = 4;
    localparam int NB  = 160;

    logic        clk4     = 1'b0;
    logic        n_reset2 = 1'b0;
    logic        cpu_wr   = 1'b0;
    logic        cpu_rd   = 1'b0;
    logic        ff46     = 1'b0;
    logic [15:0] cpu_a    = 16'h0000;
    logic [7:0]  d_in     = 8'h00;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  dma_din;
    logic [15:0] dma_a;
    logic        dma_run;
    logic        dma_addr_ext;
    logic        vram_to_oam;
    logic [7:0]  oam_a;
    logic [7:0]  oam_dout;
    logic        oam_dma_wr;
`ifdef OAM_DMA_BUS_BLOCK_EN
    logic        cpu_bus_block;
`endif

    oam_dma_ctrl #(
        .CLKS_PER_BYTE(CPB),
        .NUM_BYTES(NB)
    ) dut (
        .clk4(clk4),
        .n_reset2(n_reset2),
        .cpu_wr(cpu_wr),
        .cpu_rd(cpu_rd),
        .ff46(ff46),
        .cpu_a(cpu_a),
        .d_in(d_in),
        .d_out(d_out),
        .d_oe(d_oe),
        .dma_din(dma_din),
        .dma_a(dma_a),
        .dma_run(dma_run),
        .dma_addr_ext(dma_addr_ext),
        .vram_to_oam(vram_to_oam),
        .oam_a(oam_a),
        .oam_dout(oam_dout),
        .oam_dma_wr(oam_dma_wr)
`ifdef OAM_DMA_BUS_BLOCK_EN
        ,
        .cpu_bus_block(cpu_bus_block)
`endif
    );

    always #5 clk4 = ~clk4;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  d;
        logic [15:0] src;
        logic        vram;
    } exp_t;

    logic [7:0] mem [0:65535];
    assign dma_din = mem[dma_a];

    exp_t sbq[$];
    exp_t e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   trig_edge   = 0;
    int   pulses      = 0;
    int   falls       = 0;
    int   run_len     = 0;
    int   last_len    = 0;
    int   rise_lat    = 0;
    bit   run_prev    = 1'b0;
    bit   mon_on      = 1'b0;

    always @(posedge clk4) cyc <= cyc + 1;

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] s);
        return (s >= 8'hE0) ? s - 8'h20 : s;
    endfunction

    function automatic bit is_vram(input logic [15:0] a);
        return (a >= 16'h8000) && (a <= 16'h9FFF);
    endfunction

    // Monitor: pops one expected write per strobe and tracks dma_run windows.
    always @(negedge clk4) begin
        if (mon_on) begin
            if (oam_dma_wr) begin
                pulses++;
                if (sbq.size() == 0) begin
                    chk("spurious_wr", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("oam_a", oam_a, e.a);
                    chk("oam_dout", oam_dout, e.d);
                    chk("dma_a", dma_a, e.src);
                    chk("run_at_wr", dma_run, 1);
                    chk("vram_to_oam", vram_to_oam, e.vram);
                    chk("dma_addr_ext", dma_addr_ext, !e.vram);
                end
            end
            if (!dma_run) begin
                chk("flags_idle", {vram_to_oam, dma_addr_ext}, 0);
            end
            if (dma_run && !run_prev) rise_lat = cyc - trig_edge;
            if (dma_run) run_len++;
            if (!dma_run && run_prev) begin
                last_len = run_len;
                run_len  = 0;
                falls++;
            end
            run_prev = dma_run;
        end
    end

    task automatic tick();
        @(posedge clk4);
        #1;
    endtask

    task automatic trigger(input logic [7:0] v);
        logic [15:0] base;
        tick();
        sbq.delete();
        base = {fold(v), 8'h00};
        for (int i = 0; i < NB; i++) begin
            sbq.push_back('{a: 8'(i), d: mem[base + 16'(i)],
                           src: base + 16'(i), vram: is_vram(base)});
        end
        cpu_wr    = 1'b1;
        ff46      = 1'b1;
        cpu_rd    = 1'b0;
        d_in      = v;
        trig_edge = cyc + 1;
        tick();
        cpu_wr = 1'b0;
        ff46   = 1'b0;
        d_in   = 8'($urandom);
    endtask

    task automatic wait_falls(input int target);
        int t = 0;
        while (falls < target && t < 2000) begin
            cpu_rd = 1'($urandom);
            ff46   = 1'($urandom);
            tick();
            t++;
        end
        cpu_rd = 1'b0;
        ff46   = 1'b0;
        chk("done_wait", falls >= target, 1);
    endtask

    task automatic wait_pulses(input int n);
        int t = 0;
        while (pulses < n && t < 1000) begin
            tick();
            t++;
        end
        chk("pulse_wait", pulses >= n, 1);
    endtask

    task automatic full_xfer(input logic [7:0] v);
        int f;
        pulses = 0;
        f = falls;
        trigger(v);
        wait_falls(f + 1);
        chk("rise_lat", rise_lat, CPB + 1);
        chk("run_len", last_len, NB * CPB);
        chk("pulse_count", pulses, NB);
        chk("sb_empty", sbq.size(), 0);
        chk("idle_dma_a", dma_a, {fold(v), 8'h9F});
    endtask

`ifdef OAM_DMA_BUS_BLOCK_EN
    task automatic block_check(input logic [7:0] v,
                               input logic [15:0] a0,
                               input logic [15:0] a1);
        int t = 0;
        int f;
        bit src_v;
        pulses = 0;
        f = falls;
        src_v = is_vram({fold(v), 8'h00});
        trigger(v);
        while (!dma_run && t < 20) begin
            tick();
            t++;
        end
        chk("block_wait", dma_run, 1);
        cpu_a = a0;
        #1;
        chk("bus_block0", cpu_bus_block,
            (a0 < 16'hFE00) && (is_vram(a0) == src_v));
        cpu_a = a1;
        #1;
        chk("bus_block1", cpu_bus_block,
            (a1 < 16'hFE00) && (is_vram(a1) == src_v));
        cpu_a = 16'h0000;
        wait_falls(f + 1);
        chk("block_pulses", pulses, NB);
        #1;
        chk("bus_block_idle", cpu_bus_block, 0);
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int f;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < NB; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;

        n_reset2 = 1'b0;
        repeat (3) tick();
        mon_on = 1'b1;
        chk("rst_dma_run", dma_run, 0);
        chk("rst_wr", oam_dma_wr, 0);
        chk("rst_dma_a", dma_a, 0);
        chk("rst_oam_a", oam_a, 0);
        chk("rst_oam_dout", oam_dout, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_d_oe", d_oe, 0);
        chk("rst_flags", {vram_to_oam, dma_addr_ext}, 0);

        n_reset2 = 1'b1;
        pulses = 0;
        repeat (10) tick();
        chk("idle_pulses", pulses, 0);

        full_xfer(8'hC1);
        full_xfer(8'h80);
        full_xfer(8'hFE);

        cpu_rd = 1'b1;
        ff46   = 1'b1;
        #1;
        chk("rd_d_out", d_out, 8'hFE);
        chk("rd_d_oe", d_oe, 1);
        tick();
        chk("rd_no_start", dma_run, 0);
        cpu_rd = 1'b0;
        ff46   = 1'b0;
        repeat (CPB + 3) tick();
        chk("rd_no_run", dma_run, 0);

        pulses = 0;
        f = falls;
        trigger(8'hC0);
        wait_pulses(50);
        trigger(8'hD0);
        wait_falls(f + 2);
        chk("restart_pulses", pulses, 210);
        chk("restart_len", last_len, NB * CPB);
        chk("restart_rise", rise_lat, CPB + 1);
        chk("restart_sb", sbq.size(), 0);

        for (int k = 0; k < 4; k++) begin
            full_xfer(8'($urandom));
        end

`ifdef OAM_DMA_BUS_BLOCK_EN
        block_check(8'hC1, 16'hC234, 16'hFF80);
        block_check(8'h80, 16'h8100, 16'hC000);
`endif

        pulses = 0;
        trigger(8'hC3);
        wait_pulses(30);
        n_reset2 = 1'b0;
        sbq.delete();
        tick();
        chk("midrst_run", dma_run, 0);
        n_reset2 = 1'b1;
        repeat (20) tick();
        chk("midrst_pulses", pulses, 30);
        cpu_rd = 1'b1;
        ff46   = 1'b1;
        #1;
        chk("midrst_d_out", d_out, 8'h00);
        cpu_rd = 1'b0;
        ff46   = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
